// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage.
//   - Base RV opcode constants recognised by the decoder.
//   - fmt_e: instruction format classification (R/I/S/B/U/J).
//   - decoded_t: one decoded instruction as held in the stage buffers.
//     imm is kept as the 32-bit sign-extended RV immediate; the top level
//     widens it to XLEN on output. pc is held at the widest supported tag
//     width and narrowed to PC_W on output.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int PC_MAX_W = 64;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [6:0]          funct7;
    logic [4:0]          rs2;
    logic [4:0]          rs1;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [6:0]          opcode;
    fmt_e                fmt;
    logic [31:0]         imm;
    logic                illegal;
    logic [PC_MAX_W-1:0] pc;
  } decoded_t;

endpackage

// File: rtl/inst_decode_stage_imm_gen.sv
// imm_gen: purely combinational format classifier and immediate generator.
//   inst    in  32  raw instruction word
//   fmt     out     format classification (FMT_R for unknown opcodes)
//   imm     out 32  sign-extended immediate (0 for R format and illegal)
//   illegal out 1   opcode not supported or inst[1:0] != 2'b11
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output fmt_e        fmt,
  output logic [31:0] imm,
  output logic        illegal
);

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC:                   fmt = FMT_U;
      OP_JAL:                             fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: fmt = FMT_I;
      OP_BRANCH:                          fmt = FMT_B;
      OP_STORE:                           fmt = FMT_S;
      OP_REG:                             fmt = FMT_R;
      default:                            illegal = 1'b1;
    endcase
    // Compressed/non-32-bit encodings are never legal here, even if the
    // opcode table were extended later.
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
      fmt     = FMT_R;
    end
  end

  // Illegal words fall back to FMT_R, so they get imm = 0 automatically.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered RV32/RV64 decode front end with a 2-entry
// skid buffer (main entry M drives the outputs, skid entry S catches the
// instruction fetch sends while M is stalled).
//   clk, reset           clock, synchronous active-high reset
//   flush                discard both held entries (redirect)
//   in_valid/in_ready    fetch handshake; in_inst, in_pc
//   out_valid/out_ready  downstream handshake; out_pc
//   opcode/rd/funct3/rs1/rs2/funct7  raw instruction slices
//   fmt, imm, illegal    classification, XLEN sign-extended immediate
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a producer holds its payload
// stable until the transfer. in_ready is !S_full straight from a register,
// so it has no combinational path from out_ready.
module inst_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  fmt_e        dec_fmt;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  decoded_t    dec;

  decoded_t m_q, s_q;
  logic     m_valid, s_valid;
  logic     push, pop;

  imm_gen u_imm_gen (
    .inst    (in_inst),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec         = '0;
    dec.funct7  = in_inst[31:25];
    dec.rs2     = in_inst[24:20];
    dec.rs1     = in_inst[19:15];
    dec.funct3  = in_inst[14:12];
    dec.rd      = in_inst[11:7];
    dec.opcode  = in_inst[6:0];
    dec.fmt     = dec_fmt;
    dec.imm     = dec_imm;
    dec.illegal = dec_illegal;
    dec.pc      = PC_MAX_W'(in_pc);
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Invariant: S is only ever full while M is full, so !m_valid implies
  // S is empty and M can be loaded directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (push) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end
    end else if (pop) begin
      if (s_valid) begin
        // in_ready was low, so nothing new arrives this cycle.
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (push) begin
        m_q <= dec;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (push) begin
      s_q     <= dec;
      s_valid <= 1'b1;
    end
  end

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_pc    = m_q.pc[PC_W-1:0];
  assign opcode    = m_q.opcode;
  assign rd        = m_q.rd;
  assign funct3    = m_q.funct3;
  assign rs1       = m_q.rs1;
  assign rs2       = m_q.rs2;
  assign funct7    = m_q.funct7;
  assign fmt       = m_q.fmt;
  assign imm       = XLEN'($signed(m_q.imm));
  assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed decode vectors, backpressure,
// flush and mid-stall reset. A 32-bit and a 64-bit instance run in
// lock-step from the same stimulus.
module tb_inst_decode_stage;

  localparam int W = 100; // {pc[31:0], inst[31:0], fmt[2:0], imm[31:0], illegal}

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;

  logic        in_ready64, out_valid64, illegal64;
  logic [31:0] out_pc64;
  logic [63:0] imm64;
  logic [6:0]  opcode64, funct764;
  logic [4:0]  rd64, rs164, rs264;
  logic [2:0]  funct364, fmt64;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  inst_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .fmt(fmt), .imm(imm), .illegal(illegal)
  );

  inst_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .opcode(opcode64), .rd(rd64), .funct3(funct364), .rs1(rs164), .rs2(rs264),
    .funct7(funct764), .fmt(fmt64), .imm(imm64), .illegal(illegal64)
  );

  // Hand-computed decode table.
  vec_t vecs[15] = '{
    '{32'h00500093, 3'd1, 32'h00000005, 1'b0},  // addi x1,x0,5
    '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0},  // beq, offset -4
    '{32'h123452B7, 3'd4, 32'h12345000, 1'b0},  // lui x5,0x12345
    '{32'h00000000, 3'd0, 32'h00000000, 1'b1},  // all zero
    '{32'h0000007F, 3'd0, 32'h00000000, 1'b1},  // unknown opcode
    '{32'h0020A423, 3'd2, 32'h00000008, 1'b0},  // sw x2,8(x1)
    '{32'hFF9FF0EF, 3'd5, 32'hFFFFFFF8, 1'b0},  // jal x1,-8
    '{32'hFFC12283, 3'd1, 32'hFFFFFFFC, 1'b0},  // lw x5,-4(x2)
    '{32'h002081B3, 3'd0, 32'h00000000, 1'b0},  // add x3,x1,x2
    '{32'h00001517, 3'd4, 32'h00001000, 1'b0},  // auipc x10,1
    '{32'h00500091, 3'd0, 32'h00000000, 1'b1},  // inst[1:0] = 01
    '{32'h00000073, 3'd1, 32'h00000000, 1'b0},  // ecall
    '{32'h00008067, 3'd1, 32'h00000000, 1'b0},  // jalr x0,0(x1)
    '{32'h00000463, 3'd3, 32'h00000008, 1'b0},  // beq, offset +8
    '{32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 1'b0}   // sw x2,-4(x1)
  };

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one instruction, hold until accepted (bounded).
  // in_ready is registered, so its value just after an edge is the value
  // seen at the next edge.
  task automatic send(input logic [31:0] pc, input vec_t v);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_pc    = pc;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc %0h not accepted within 20 cycles", pc);
    end else begin
      exp_q.push_back({pc, v.inst, v.fmt, v.imm, v.ill});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor / scoreboard: compare on every downstream transfer.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %0h inst %0h, expected nothing", out_pc,
                 {funct7, rs2, rs1, funct3, rd, opcode});
      end else begin
        e = exp_q.pop_front();
        chk("decode32", {out_pc, funct7, rs2, rs1, funct3, rd, opcode, fmt, imm, illegal}, e);
        chk("decode64", {out_pc64, funct764, rs264, rs164, funct364, rd64, opcode64, fmt64,
                         imm64[31:0], illegal64}, e);
        chk("imm64_sign", imm64[63:32], {32{e[32]}});
        chk("valid64", out_valid64, 1'b1);
        chk("ready64", in_ready64, in_ready);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0);
    chk("rst_fmt", fmt, 3'd0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_imm64", imm64, 64'h0);

    // Streaming decode, downstream always ready
    for (int i = 0; i < 15; i++) send(32'h100 + 32'(4 * i), vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 4 stalled cycles while offering 0x0, 0x4, 0x8
    out_ready = 1'b0;
    send(32'h0, vecs[0]);
    send(32'h4, vecs[1]);
    fork
      send(32'h8, vecs[2]);
      begin
        chk("bp_in_ready_low", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_no_gap", out_valid, 1'b1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);

    // Flush with both entries full; offered instruction must vanish
    out_ready = 1'b0;
    send(32'h200, vecs[5]);
    send(32'h204, vecs[6]);
    chk("fl_full_ready", in_ready, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_inst = vecs[7].inst; in_pc = 32'h208;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);

    // Flush while an accept would otherwise happen
    send(32'h300, vecs[8]);
    flush = 1'b1; in_valid = 1'b1; in_inst = vecs[9].inst; in_pc = 32'h304;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", out_valid, 1'b0);
    chk("fl2_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("fl2_discarded", out_valid, 1'b0);

    // Reset in the middle of a stall
    send(32'h500, vecs[10]);
    send(32'h504, vecs[11]);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_in_ready", in_ready, 1'b1);
    chk("mr_out_pc", out_pc, 32'h0);
    chk("mr_imm", imm, 32'h0);

    // Recovery after flush/reset
    out_ready = 1'b1;
    send(32'h400, vecs[2]);
    send(32'h404, vecs[14]);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    #1;
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Registered RV32/RV64 instruction-decode front end for the pipelined processor; sits between the fetch stage and the register file / control unit.
- Splits the instruction word into its fields, classifies the format, generates the sign-extended immediate, and flags illegal encodings.
- Uses a valid/ready handshake with a 2-entry skid buffer so fetch never loses an instruction under stall.
- Supports a flush for branch redirection.

Parameters:
- XLEN, 32, datapath width; immediate sign-extended to XLEN (legal values 32 or 64)
- PC_W, 32, width of the program-counter tag carried alongside the instruction

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (branch/jump redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_inst
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of decoded entry
- opcode  out  7  inst[6:0]
- rd  out  5  inst[11:7]
- funct3  out  3  inst[14:12]
- rs1  out  5  inst[19:15]
- rs2  out  5  inst[24:20]
- funct7  out  7  inst[31:25]
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
- imm  out  XLEN  sign-extended immediate; 0 for R format
- illegal  out  1  unsupported or malformed encoding

Behaviour:
- Reset: out_valid=0, in_ready=1 in the cycle after reset; all field outputs, imm, fmt, illegal, out_pc=0; both buffer entries empty.
- Storage: main entry M drives the outputs; skid entry S. Decode is combinational on input, and the decoded result is stored, so outputs are registered.
- Latency: an instruction accepted in cycle N is visible on the outputs in cycle N+1.
- Accept when in_valid & in_ready. Release when out_valid & out_ready.
- in_ready = !S_full, registered, so it never depends combinationally on out_ready.
- M empty: an accepted instruction loads M.
- M full, released, S empty: an accepted instruction loads M.
- M full, released, S full: S moves to M. in_ready was 0, so nothing is accepted.
- M full, not released: an accepted instruction loads S.
- Order is strictly FIFO. No drops or duplicates.
- Flush: the next cycle shows out_valid=0 and S empty. An accept in the flush cycle is discarded. in_ready=1 the next cycle. Flush has priority over accept and release.
- Reset has priority over flush.
- Format mapping:
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1100111, 0000011, 0010011, 1110011 → I
  - 1100011 → B
  - 0100011 → S
  - 0110011 → R
  - any other opcode → illegal=1, fmt=R, imm=0
- Immediates (standard RV layout, sign bit inst[31], extended to XLEN):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- illegal is also set when inst[1:0] != 2'b11.
- Illegal entries still flow through the handshake; downstream traps.
- Field outputs are raw slices even for formats where a field is unused.

Decomposition:
- Shared package (decode_pkg):
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM)
  - fmt_e enum
  - decoded_t packed struct {fields, fmt, imm, illegal, pc}
- One combinational sub-module, imm_gen (inst → fmt, imm, illegal).
- The top level holds the M/S registers and the handshake logic.

Test Plan:
- Decode addi: 0x00500093 with out_ready=1 → next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, fmt=I, imm=5, illegal=0.
- Decode beq with negative offset: 0xFE000EE3 → fmt=B, imm=0xFFFFFFFC (XLEN=32); with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
- Decode lui: 0x123452B7 → fmt=U, rd=5, imm=0x12345000.
- Illegal encodings: 0x00000000 → illegal=1, fmt=R, imm=0; 0x0000007F → illegal=1.
- Backpressure: out_ready=0 for 4 cycles while offering PCs 0x0, 0x4, 0x8 back-to-back:
  - 0x0 and 0x4 accepted, then in_ready=0.
  - On out_ready=1, outputs appear as 0x0, 0x4, 0x8 with no gaps or loss.
- Flush with both entries full → next cycle out_valid=0, in_ready=1. The instruction offered in the flush cycle never appears. Reset asserted mid-stall gives the same empty result.
